instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the program address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles to wait for w to fall after s is raised.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port run, input, 1 bit: level request to start or continue program execution.
REQ-006 The block SHALL have port mem_addr, output, ADDR_W bits: program memory read address.
REQ-007 The block SHALL have port mem_rdata, input, 16 bits: program memory data, valid one cycle after mem_addr.
REQ-008 The block SHALL have port in, output, 16 bits: instruction word to the cpu.
REQ-009 The block SHALL have port load, output, 1 bit: instruction-register load enable to the cpu.
REQ-010 The block SHALL have port s, output, 1 bit: start request to the cpu.
REQ-011 The block SHALL have port w, input, 1 bit: cpu waiting/idle flag.
REQ-012 The block SHALL have port pc, output, ADDR_W bits: current program counter.
REQ-013 The block SHALL have port retired, output, 16 bits: count of completed instructions.
REQ-014 The block SHALL have ports halted and error, outputs, 1 bit each: terminal status flags.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, FWAIT, LOAD, START, EXEC, HALT and ERR.
REQ-016 IDLE SHALL move to FETCH when run=1 and w=1, and otherwise hold.
REQ-017 FETCH SHALL drive mem_addr=pc and move to FWAIT.
REQ-018 FWAIT SHALL capture mem_rdata into an internal 16-bit instruction register; if the word is 16'hE000 (HALT), it SHALL go to HALT, otherwise to LOAD.
REQ-019 LOAD SHALL drive in=captured word and load=1 for exactly one cycle, then go to START.
REQ-020 START SHALL hold s=1 and keep in stable until w is sampled 0, then go to EXEC with s=0 on the next cycle.
REQ-021 In START, s SHALL never be high while the block is in any state other than START.
REQ-022 START SHALL increment a watchdog counter each cycle; if w is still 1 after TIMEOUT cycles, the block SHALL go to ERR with s=0. Unknown opcodes therefore end in ERR.
REQ-023 EXEC SHALL wait for w=1, then increment pc (modulo 2^ADDR_W, wrapping from max to 0), increment retired (saturating at 16'hFFFF), and go to FETCH if run=1 or to IDLE if run=0.
REQ-024 Deasserting run SHALL NOT abort an instruction in progress; it takes effect only at the EXEC exit.
REQ-025 HALT SHALL assert halted=1, leave pc at the HALT word's address, and hold until reset.
REQ-026 ERR SHALL assert error=1, leave pc at the faulting address, and hold until reset.
REQ-027 Outside LOAD and START, load SHALL be 0 and in SHALL hold its last value.
REQ-028 Fetch-to-load latency SHALL be 3 cycles from entering FETCH to load=1.

Reset
REQ-029 Reset=1 SHALL immediately force state IDLE, pc=0, retired=0, load=0, s=0, in=0, mem_addr=0, halted=0, error=0, and clear the watchdog.
REQ-030 Reset asserted mid-instruction SHALL drop s and load in the same cycle, with no pc or retired update.

Structure
REQ-031 State encodings, the HALT word (16'hE000) and the default TIMEOUT SHALL live in a shared package, alongside the cpu opcode constants.
REQ-032 The block SHALL be a single module; the watchdog MAY be a sub-module named wdog_counter.

Verification
REQ-033 Bench case, two-instruction run: program [0]=MOV R0,#5 (16'hD005), [1]=16'hE000, run=1 -> one load pulse with in=16'hD005, then halted=1, pc=1, retired=1.
REQ-034 Bench case, retirement counting: ADD/CMP/MVN sequence of 3 instructions then HALT -> retired=3, and s is never high while w=0 at EXEC exit.
REQ-035 Bench case, unknown opcode: word 16'h0000 at pc=0, w held 1 -> s high for TIMEOUT=16 cycles, then error=1, s=0, pc=0.
REQ-036 Bench case, wrap: ADDR_W=2, no HALT, 4 instructions executed -> pc wraps 3->0, retired=4.
REQ-037 Bench case, run dropped: run falls during EXEC -> the current instruction retires, then the block returns to IDLE; raising run again resumes at pc+1.
REQ-038 Bench case, reset mid-instruction: reset asserted in START -> s=0 asynchronously, pc=0, retired=0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch/sequencer: FSM encodings,
// special words, defaults and the cpu opcode map.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    FWAIT = 3'd2,
    LOAD  = 3'd3,
    START = 3'd4,
    EXEC  = 3'd5,
    HALT  = 3'd6,
    ERR   = 3'd7
  } state_t;

  localparam logic [15:0] HALT_WORD   = 16'hE000;
  localparam int          DEF_TIMEOUT = 16;
  localparam int          DEF_ADDR_W  = 8;

  // cpu opcodes live in the top nibble of the instruction word
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_CMP  = 4'h5;
  localparam logic [3:0] OP_MVN  = 4'hB;
  localparam logic [3:0] OP_MOV  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hE;

  function automatic logic is_known_op(input logic [15:0] word);
    case (word[15:12])
      OP_ADD, OP_SUB, OP_CMP, OP_MVN, OP_MOV: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_wdog.sv
// Watchdog for the START handshake: counts cycles spent waiting for the cpu
// to accept s, flagging expiry on the TIMEOUT-th cycle.
module wdog_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction sequencer: fetches a word, hands it to the cpu with load/s,
// waits for completion on w, then retires and advances pc.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       in,
  output logic              load,
  output logic              s,
  input  logic              w,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       retired,
  output logic              halted,
  output logic              error
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       retired_q, retired_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       in_q, in_d;
  logic              wd_expired;

  wdog_counter #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (reset),
    .clr     (state_q != START),
    .en      (state_q == START),
    .expired (wd_expired)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (run && w) state_d = FETCH;
      FETCH: state_d = FWAIT;
      FWAIT: state_d = (mem_rdata == HALT_WORD) ? HALT : LOAD;
      LOAD:  state_d = START;
      START: begin
        if (!w)              state_d = EXEC;
        else if (wd_expired) state_d = ERR;
      end
      // run is only consulted here, so dropping it never aborts an instruction
      EXEC:  if (w) state_d = run ? FETCH : IDLE;
      HALT:  state_d = HALT;
      ERR:   state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from state so reset removes s/load without waiting for a clock
  always_comb begin
    load   = 1'b0;
    s      = 1'b0;
    halted = 1'b0;
    error  = 1'b0;
    case (state_q)
      LOAD:    load   = 1'b1;
      START:   s      = 1'b1;
      HALT:    halted = 1'b1;
      ERR:     error  = 1'b1;
      default: ;
    endcase
  end

  // in shows the fresh word during LOAD and keeps it afterwards; a HALT word never reaches it
  assign in       = (state_q == LOAD) ? ir_q : in_q;
  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign retired  = retired_q;

  always_comb begin
    pc_d      = pc_q;
    retired_d = retired_q;
    ir_d      = ir_q;
    in_d      = in_q;
    if (state_q == FWAIT)
      ir_d = mem_rdata;
    if (state_q == LOAD)
      in_d = ir_q;
    if (state_q == EXEC && w) begin
      pc_d      = pc_q + 1'b1;
      retired_d = sat_inc16(retired_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      retired_q <= '0;
      ir_q      <= '0;
      in_q      <= '0;
    end else begin
      pc_q      <= pc_d;
      retired_q <= retired_d;
      ir_q      <= ir_d;
      in_q      <= in_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small program memory and a cpu model
// that accepts known opcodes and ignores unknown ones.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic run2 = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem_addr, pc;
  logic [15:0] mem_rdata, in, retired;
  logic        load, s, w, halted, error;
  logic [15:0] mem [256];

  logic [1:0]  mem_addr2, pc2;
  logic [15:0] mem_rdata2, in2, retired2;
  logic        load2, s2, w2, halted2, error2;
  logic [15:0] mem2 [4];

  int checks = 0;
  int errors = 0;

  instr_fetch #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .in(in), .load(load), .s(s), .w(w), .pc(pc), .retired(retired),
    .halted(halted), .error(error)
  );

  instr_fetch #(.ADDR_W(2), .TIMEOUT(16)) dut2 (
    .clk(clk), .reset(reset), .run(run2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
    .in(in2), .load(load2), .s(s2), .w(w2), .pc(pc2), .retired(retired2),
    .halted(halted2), .error(error2)
  );

  // synchronous program memories, data one cycle after address
  always @(posedge clk) mem_rdata  <= mem[mem_addr];
  always @(posedge clk) mem_rdata2 <= mem2[mem_addr2];

  // cpu models: accept s on a known opcode, drop w, busy 3 cycles, raise w
  int busy, busy2;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      w <= 1'b1; busy <= 0;
    end else if (w && s && is_known_op(in)) begin
      w <= 1'b0; busy <= 2;
    end else if (!w) begin
      if (busy == 0) w <= 1'b1;
      else           busy <= busy - 1;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      w2 <= 1'b1; busy2 <= 0;
    end else if (w2 && s2 && is_known_op(in2)) begin
      w2 <= 1'b0; busy2 <= 2;
    end else if (!w2) begin
      if (busy2 == 0) w2 <= 1'b1;
      else            busy2 <= busy2 - 1;
    end
  end

  // activity monitor on dut, cleared while reset is held
  int          load_cnt, load_run, load_run_max, s_starts, s_hi_cyc, s_lo_w_run, s_stuck;
  logic [15:0] last_in;
  logic        s_prev;
  always @(negedge clk) begin
    if (reset) begin
      load_cnt <= 0; load_run <= 0; load_run_max <= 0; s_starts <= 0;
      s_hi_cyc <= 0; s_lo_w_run <= 0; s_stuck <= 0; last_in <= '0; s_prev <= 1'b0;
    end else begin
      if (load) begin
        load_cnt <= load_cnt + 1;
        load_run <= load_run + 1;
        last_in  <= in;
        if (load_run + 1 > load_run_max) load_run_max <= load_run + 1;
      end else begin
        load_run <= 0;
      end
      if (s) s_hi_cyc <= s_hi_cyc + 1;
      if (s && !s_prev) s_starts <= s_starts + 1;
      // s may overlap w=0 for the one cycle it takes to notice; never longer
      if (s && !w) begin
        s_lo_w_run <= s_lo_w_run + 1;
        if (s_lo_w_run >= 1) s_stuck <= s_stuck + 1;
      end else begin
        s_lo_w_run <= 0;
      end
      s_prev <= s;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; run2 = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_retired", retired, 0);
    chk("rst_in", in, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_s", s, 0);
    chk("rst_load", load, 0);
    chk("rst_halted", halted, 0);
    chk("rst_error", error, 0);
    chk("rst_pc2", pc2, 0);
    reset = 1'b0;
  endtask

  int lat;
  logic [1:0] pv;

  initial begin
    // two-instruction run and fetch latency
    clr_mem();
    mem[0] = 16'hD005; mem[1] = HALT_WORD;
    do_reset();
    run = 1'b1;
    lat = 0;
    while (!load && lat < 20) begin @(negedge clk); lat++; end
    chk("A_latency", lat, 3);
    chk("A_in_at_load", in, 16'hD005);
    for (int i = 0; i < 100 && !halted && !error; i++) @(negedge clk);
    chk("A_halted", halted, 1);
    chk("A_error", error, 0);
    chk("A_pc", pc, 1);
    chk("A_retired", retired, 1);
    chk("A_load_cnt", load_cnt, 1);
    chk("A_last_in", last_in, 16'hD005);
    repeat (5) @(negedge clk);
    chk("A_hold_halted", halted, 1);
    chk("A_hold_pc", pc, 1);
    chk("A_hold_in", in, 16'hD005);

    // retirement counting over ADD / CMP / MVN
    clr_mem();
    mem[0] = 16'h1123; mem[1] = 16'h5012; mem[2] = 16'hB0FF; mem[3] = HALT_WORD;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 200 && !halted && !error; i++) @(negedge clk);
    chk("B_halted", halted, 1);
    chk("B_retired", retired, 3);
    chk("B_pc", pc, 3);
    chk("B_load_cnt", load_cnt, 3);
    chk("B_load_width", load_run_max, 1);
    chk("B_s_starts", s_starts, 3);
    chk("B_s_stuck", s_stuck, 0);
    chk("B_last_in", last_in, 16'hB0FF);

    // unknown opcode: watchdog expiry
    clr_mem();
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 100 && !error && !halted; i++) @(negedge clk);
    chk("C_error", error, 1);
    chk("C_halted", halted, 0);
    chk("C_s", s, 0);
    chk("C_pc", pc, 0);
    chk("C_retired", retired, 0);
    chk("C_s_cycles", s_hi_cyc, 16);
    chk("C_load_cnt", load_cnt, 1);
    repeat (5) @(negedge clk);
    chk("C_hold_error", error, 1);
    chk("C_hold_s", s, 0);

    // run dropped during EXEC
    clr_mem();
    mem[0] = 16'hD005; mem[1] = 16'h1123; mem[2] = HALT_WORD;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 50 && !s; i++) @(negedge clk);
    chk("D_s_rise", s, 1);
    for (int i = 0; i < 50 && s; i++) @(negedge clk);
    chk("D_s_fall", s, 0);
    run = 1'b0;
    for (int i = 0; i < 50 && retired != 16'd1; i++) @(negedge clk);
    chk("D_retired_1", retired, 1);
    chk("D_pc_1", pc, 1);
    repeat (10) @(negedge clk);
    chk("D_idle_retired", retired, 1);
    chk("D_idle_pc", pc, 1);
    chk("D_idle_load_cnt", load_cnt, 1);
    chk("D_idle_s", s, 0);
    run = 1'b1;
    for (int i = 0; i < 100 && !halted && !error; i++) @(negedge clk);
    chk("D_halted", halted, 1);
    chk("D_retired_2", retired, 2);
    chk("D_pc_2", pc, 2);
    chk("D_last_in", last_in, 16'h1123);
    chk("D_load_cnt", load_cnt, 2);

    // reset while the second instruction sits in START
    clr_mem();
    mem[0] = 16'h1123; mem[1] = 16'hD005; mem[2] = HALT_WORD;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 50 && retired != 16'd1; i++) @(negedge clk);
    for (int i = 0; i < 50 && !s; i++) @(negedge clk);
    chk("E_pre_s", s, 1);
    chk("E_pre_retired", retired, 1);
    chk("E_pre_pc", pc, 1);
    reset = 1'b1;
    #1;
    chk("E_s", s, 0);
    chk("E_load", load, 0);
    chk("E_pc", pc, 0);
    chk("E_retired", retired, 0);
    chk("E_in", in, 0);

    // pc wrap on a 2-bit address instance
    for (int i = 0; i < 4; i++) mem2[i] = 16'hD001 + 16'(i);
    do_reset();
    run2 = 1'b1;
    pv = pc2;
    for (int i = 0; i < 200 && retired2 != 16'd4; i++) begin pv = pc2; @(negedge clk); end
    chk("F_retired", retired2, 4);
    chk("F_pc_wrapped", pc2, 0);
    chk("F_pc_before", pv, 3);
    chk("F_error", error2, 0);
    run2 = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
